apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 177 +++++++++++++++++
 tb/tb_apb_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB master: turns one local command at a time into an APB
// SETUP/ACCESS transfer and returns a one-cycle completion pulse.
// ACCESS can be cut short by a wait-cycle timeout, which completes as an error.
module apb_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int BUS_WIDTH      = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int MAX_DIM       = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [MAX_DIM-1:0]    cmd_strb_i,
  output logic                  rsp_valid_o,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_slverr_o,
  output logic                  rsp_timeout_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i
);

  // A zero limit turns the timeout off entirely; otherwise the transfer
  // gives up on the ACCESS cycle whose wait count is one below the limit,
  // i.e. after exactly TIMEOUT_CYCLES cycles without pready.
  localparam bit         TimeoutEn = (TIMEOUT_CYCLES > 0);
  localparam logic [7:0] WaitLast  = TimeoutEn ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [MAX_DIM-1:0]    pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [BUS_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;

  // Next-state and next-output computation; every output is a register.
  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = cmd_write_i;
          paddr_d     = cmd_addr_i;
          pwdata_d    = cmd_write_i ? cmd_wdata_i : '0;
          pstrb_d     = cmd_write_i ? cmd_strb_i : '0;
        end
      end
      SETUP: begin
        state_d    = ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = 8'd0;
      end
      ACCESS: begin
        if (pready_i) begin
          state_d       = IDLE;
          cmd_ready_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          pwdata_d      = '0;
          pstrb_d       = '0;
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = pslverr_i;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
        end else if (TimeoutEn && (wait_cnt_q == WaitLast)) begin
          state_d       = IDLE;
          cmd_ready_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          pwdata_d      = '0;
          pstrb_d       = '0;
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        pwdata_d    = '0;
        pstrb_d     = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer silently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_slverr_o  = rsp_slverr_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: directed commands against a simple APB slave
// model, with a scoreboard queue checked by an independent monitor.
module tb_apb_master;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [63:0] cmd_wdata_i;
  logic [1:0]  cmd_strb_i;
  logic        rsp_valid_o, rsp_slverr_o, rsp_timeout_o;
  logic [63:0] rsp_rdata_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o;
  logic [63:0] pwdata_o;
  logic [1:0]  pstrb_o;
  logic        pready_i, pslverr_i;
  logic [63:0] prdata_i;

  apb_master #(
    .DATA_WIDTH(32), .BUS_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_slverr_o(rsp_slverr_o), .rsp_timeout_o(rsp_timeout_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        write;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [1:0]  strb;
    int          slvWait;
    bit          slvHang;
    logic        slvErr;
    logic [63:0] slvRdata;
    logic [63:0] expRdata;
    logic        expSlverr;
    logic        expTimeout;
    int          expLat;
    int          expPsel;
    int          expPen;
  } vec_t;

  vec_t        sbQ[$];
  int          checks = 0;
  int          failures = 0;
  int          slvWait = 0;
  bit          slvHang = 1'b0;
  logic        slvErr = 1'b0;
  logic [63:0] slvRdata = '0;

  // Shared comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mkVec(input string name, input logic write, input logic [31:0] addr,
                                 input logic [63:0] wdata, input logic [1:0] strb,
                                 input int sw, input bit hang, input logic err,
                                 input logic [63:0] rd, input logic [63:0] eRd,
                                 input logic eErr, input logic eTo,
                                 input int lat, input int ps, input int pe);
    vec_t v;
    v.name = name; v.write = write; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.slvWait = sw; v.slvHang = hang; v.slvErr = err; v.slvRdata = rd;
    v.expRdata = eRd; v.expSlverr = eErr; v.expTimeout = eTo;
    v.expLat = lat; v.expPsel = ps; v.expPen = pe;
    return v;
  endfunction

  // Slave model: answers only in ACCESS, drives junk elsewhere so that
  // any sampling outside ACCESS shows up as a wrong response.
  int accCnt = 0;
  always @(negedge clk_i) begin
    if (psel_o && penable_o) begin
      pready_i  = !slvHang && (accCnt >= slvWait);
      pslverr_i = slvErr;
      prdata_i  = slvRdata;
      accCnt++;
    end else begin
      accCnt    = 0;
      pready_i  = 1'b1;
      pslverr_i = 1'b1;
      prdata_i  = '1;
    end
  end

  // Monitor: tracks the live transfer and pops the scoreboard on each response.
  longint cyc = 0;
  longint acceptCyc = 0;
  int     pselCnt = 0;
  int     penCnt = 0;
  int     busErr = 0;
  always @(negedge clk_i) begin
    vec_t e;
    cyc++;
    if (!rst_ni) begin
      pselCnt = 0; penCnt = 0; busErr = 0;
    end else begin
      if (rsp_valid_o) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput({e.name, "_rdata"}, rsp_rdata_o, e.expRdata);
          checkOutput({e.name, "_slverr"}, 64'(rsp_slverr_o), 64'(e.expSlverr));
          checkOutput({e.name, "_timeout"}, 64'(rsp_timeout_o), 64'(e.expTimeout));
          checkOutput({e.name, "_latency"}, 64'(cyc - acceptCyc), 64'(e.expLat));
          checkOutput({e.name, "_psel_cycles"}, 64'(pselCnt), 64'(e.expPsel));
          checkOutput({e.name, "_penable_cycles"}, 64'(penCnt), 64'(e.expPen));
          checkOutput({e.name, "_bus_stable"}, 64'(busErr), 64'd0);
        end
        pselCnt = 0; penCnt = 0; busErr = 0;
      end
      if (psel_o) begin
        pselCnt++;
        if (penable_o) penCnt++;
        if (sbQ.size() > 0) begin
          if (pwrite_o !== sbQ[0].write || paddr_o !== sbQ[0].addr ||
              pwdata_o !== (sbQ[0].write ? sbQ[0].wdata : 64'd0) ||
              pstrb_o !== (sbQ[0].write ? sbQ[0].strb : 2'b00))
            busErr++;
        end
      end
      if (cmd_valid_i && cmd_ready_o) acceptCyc = cyc;
    end
  end

  // Waits (bounded) until the command currently driven is accepted.
  task automatic waitAccept(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (cmd_ready_o) ok = 1'b1;
      @(posedge clk_i); #1;
    end
    checkOutput({name, "_accepted"}, 64'(ok), 64'd1);
  endtask

  // Issues one command, leaving cmd_valid_i high when hold is set.
  task automatic applyStimulus(input vec_t v, input bit hold);
    slvWait = v.slvWait; slvHang = v.slvHang; slvErr = v.slvErr; slvRdata = v.slvRdata;
    sbQ.push_back(v);
    cmd_write_i = v.write;
    cmd_addr_i  = v.addr;
    cmd_wdata_i = v.write ? v.wdata : 64'hFFFF_0000_FFFF_0000;
    cmd_strb_i  = v.write ? v.strb : 2'b11;
    cmd_valid_i = 1'b1;
    waitAccept(v.name);
    if (!hold) cmd_valid_i = 1'b0;
  endtask

  // Bounded wait for every outstanding response to be seen by the monitor.
  task automatic waitDone(input string name);
    for (int i = 0; i < 60 && sbQ.size() != 0; i++) begin
      @(posedge clk_i); #1;
    end
    checkOutput({name, "_done"}, 64'(sbQ.size()), 64'd0);
    @(posedge clk_i); #1;
  endtask

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawAccess;
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0;
    cmd_addr_i = '0; cmd_wdata_i = '0; cmd_strb_i = '0;
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset_psel", 64'(psel_o), 64'd0);
    checkOutput("reset_penable", 64'(penable_o), 64'd0);
    checkOutput("reset_paddr", 64'(paddr_o), 64'd0);
    checkOutput("reset_rsp", {rsp_rdata_o[61:0], rsp_valid_o, rsp_slverr_o}, 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("reset_ready", 64'(cmd_ready_o), 64'd1);

    // Plain write, immediate pready.
    applyStimulus(mkVec("wr_fast", 1'b1, 32'h10, 64'h1122334455667788, 2'b11,
                        0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 3, 2, 1), 1'b0);
    waitDone("wr_fast");
    checkOutput("idle_paddr_hold", 64'(paddr_o), 64'h10);
    checkOutput("idle_pwrite_hold", 64'(pwrite_o), 64'd1);
    checkOutput("idle_pwdata_zero", pwdata_o, 64'd0);
    checkOutput("idle_pstrb_zero", 64'(pstrb_o), 64'd0);

    // Read with two wait cycles.
    applyStimulus(mkVec("rd_wait2", 1'b0, 32'h20, 64'h0, 2'b00,
                        2, 1'b0, 1'b0, 64'hDEADBEEF, 64'hDEADBEEF, 1'b0, 1'b0, 5, 4, 3), 1'b0);
    waitDone("rd_wait2");
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rdata_hold", rsp_rdata_o, 64'hDEADBEEF);
    checkOutput("rsp_valid_single", 64'(rsp_valid_o), 64'd0);

    // Write answered with a slave error.
    applyStimulus(mkVec("wr_slverr", 1'b1, 32'h30, 64'hA5A5, 2'b01,
                        0, 1'b0, 1'b1, 64'h0, 64'h0, 1'b1, 1'b0, 3, 2, 1), 1'b0);
    waitDone("wr_slverr");

    // Slave never answers: timeout after four wait cycles.
    applyStimulus(mkVec("rd_timeout", 1'b0, 32'h40, 64'h0, 2'b00,
                        0, 1'b1, 1'b0, 64'h1234, 64'h0, 1'b1, 1'b1, 6, 5, 4), 1'b0);
    waitDone("rd_timeout");

    // pready arrives on the very cycle the timeout would fire.
    applyStimulus(mkVec("wr_at_limit", 1'b1, 32'h50, 64'h0F0F, 2'b10,
                        3, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 6, 5, 4), 1'b0);
    waitDone("wr_at_limit");

    // Read that completes with an error still returns its data.
    applyStimulus(mkVec("rd_err", 1'b0, 32'h58, 64'h0, 2'b00,
                        0, 1'b0, 1'b1, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF,
                        1'b1, 1'b0, 3, 2, 1), 1'b0);
    waitDone("rd_err");

    // Reset pulse in the middle of ACCESS aborts without a response.
    applyStimulus(mkVec("rd_aborted", 1'b0, 32'h44, 64'h0, 2'b00,
                        0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 0, 0, 0), 1'b0);
    sawAccess = 1'b0;
    for (int i = 0; i < 10 && !sawAccess; i++) begin
      if (psel_o && penable_o) sawAccess = 1'b1;
      else begin @(posedge clk_i); #1; end
    end
    checkOutput("abort_reached_access", 64'(sawAccess), 64'd1);
    #2;
    rst_ni = 1'b0;
    sbQ.delete();
    #1;
    checkOutput("abort_psel_async", 64'(psel_o), 64'd0);
    checkOutput("abort_penable_async", 64'(penable_o), 64'd0);
    checkOutput("abort_no_rsp", 64'(rsp_valid_o), 64'd0);
    checkOutput("abort_ready", 64'(cmd_ready_o), 64'd1);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    slvHang = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    applyStimulus(mkVec("wr_after_reset", 1'b1, 32'h60, 64'hBEEF, 2'b11,
                        0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 3, 2, 1), 1'b0);
    waitDone("wr_after_reset");

    // cmd_valid held through a busy transfer: second command waits for IDLE.
    applyStimulus(mkVec("b2b_a", 1'b1, 32'h70, 64'hCAFE, 2'b10,
                        0, 1'b0, 1'b0, 64'h55AA, 64'h0, 1'b0, 1'b0, 3, 2, 1), 1'b1);
    checkOutput("b2b_busy_ready", 64'(cmd_ready_o), 64'd0);
    applyStimulus(mkVec("b2b_b", 1'b0, 32'h80, 64'h0, 2'b00,
                        0, 1'b0, 1'b0, 64'h55AA, 64'h55AA, 1'b0, 1'b0, 3, 2, 1), 1'b0);
    waitDone("b2b");
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("final_queue_empty", 64'(sbQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
